// File: rtl/clock_display_scan.sv
// Purpose : Scans a 4-digit common-anode seven-segment display from a BCD HH:MM word,
//           with a once-per-frame snapshot, set-mode blinking and a run-mode flashing colon.
// Latency : outputs are registered, one clock after the scan/blink state they reflect.
// Ports   : clk, rst (async, active high); clock_bin[15:0] BCD time; mode[1:0]
//           (0/3 run, 1 hour set, 2 minute set); an[3:0] digit enables, seg[6:0]
//           {g,f,e,d,c,b,a} and dp, all active low.
// Option  : define LEADING_ZERO_BLANK_EN to blank digit 3 whenever the hour tens nibble is 0.
module clock_display_scan #(
    parameter int REFRESH_DIV = 50000,
    parameter int BLINK_DIV   = 25000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] clock_bin,
    input  logic [1:0]  mode,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int PW = $clog2(REFRESH_DIV);
    localparam int BW = $clog2(BLINK_DIV);
    localparam logic [PW-1:0] P_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [BW-1:0] B_LAST = BW'(BLINK_DIV - 1);

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    // Scan and blink state
    logic [PW-1:0] r_pcnt;
    logic [1:0]    r_dig;
    logic [15:0]   r_snap;
    logic [BW-1:0] r_bcnt;
    logic          r_blink_ph;

    // Registered pin drivers
    logic [3:0]    r_an;
    logic [6:0]    r_seg;
    logic          r_dp;

    logic          w_scan_tick;
    logic          w_blink_tick;
    logic [3:0]    w_nib;
    logic [6:0]    w_seg_dec;
    logic          w_hour_set;
    logic          w_min_set;
    logic          w_blink_blank;
    logic          w_lz_blank;
    logic          w_blank;
    logic [3:0]    w_an;
    logic [6:0]    w_seg;
    logic          w_dp;

    assign w_scan_tick  = (r_pcnt == P_LAST);
    assign w_blink_tick = (r_bcnt == B_LAST);
    assign w_hour_set   = (mode == 2'd1);
    assign w_min_set    = (mode == 2'd2);

    // Nibble for the digit currently selected; digit 0 is the rightmost (minute units).
    always_comb begin
        w_nib = 4'd0;
        case (r_dig)
            2'd0:    w_nib = r_snap[3:0];
            2'd1:    w_nib = r_snap[7:4];
            2'd2:    w_nib = r_snap[11:8];
            default: w_nib = r_snap[15:12];
        endcase
    end

    always_comb begin
        w_seg_dec = SEG_DASH;
        case (w_nib)
            4'd0:    w_seg_dec = 7'b1000000;
            4'd1:    w_seg_dec = 7'b1111001;
            4'd2:    w_seg_dec = 7'b0100100;
            4'd3:    w_seg_dec = 7'b0110000;
            4'd4:    w_seg_dec = 7'b0011001;
            4'd5:    w_seg_dec = 7'b0010010;
            4'd6:    w_seg_dec = 7'b0000010;
            4'd7:    w_seg_dec = 7'b1111000;
            4'd8:    w_seg_dec = 7'b0000000;
            4'd9:    w_seg_dec = 7'b0010000;
            default: w_seg_dec = SEG_DASH;   // non-BCD nibble
        endcase
    end

    // The digit group being edited goes dark during the "on" half of the blink.
    assign w_blink_blank = r_blink_ph &&
                           ((w_hour_set && r_dig[1]) || (w_min_set && !r_dig[1]));

`ifdef LEADING_ZERO_BLANK_EN
    assign w_lz_blank = (r_dig == 2'd3) && (r_snap[15:12] == 4'd0);
`else
    assign w_lz_blank = 1'b0;
`endif

    assign w_blank = w_blink_blank || w_lz_blank;

    always_comb begin
        w_an  = 4'b1111;
        w_seg = SEG_BLANK;
        if (!w_blank) begin
            w_an[r_dig] = 1'b0;
            w_seg       = w_seg_dec;
        end
    end

    // Colon lives on digit 2's decimal point: flashes in run mode, steady while setting.
    // An unlit anode hides it when that digit is blanked, so blanking does not gate it.
    assign w_dp = (r_dig != 2'd2)            ? 1'b1 :
                  (w_hour_set || w_min_set)  ? 1'b0 : r_blink_ph;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pcnt     <= '0;
            r_dig      <= 2'd0;
            r_snap     <= 16'h0000;
            r_bcnt     <= '0;
            r_blink_ph <= 1'b0;
            r_an       <= 4'b1111;
            r_seg      <= SEG_BLANK;
            r_dp       <= 1'b1;
        end else begin
            if (w_scan_tick) begin
                r_pcnt <= '0;
                r_dig  <= r_dig + 2'd1;
                // Capture the time only as the scan wraps so a frame never mixes two times.
                if (r_dig == 2'd3) begin
                    r_snap <= clock_bin;
                end
            end else begin
                r_pcnt <= r_pcnt + PW'(1);
            end

            if (w_blink_tick) begin
                r_bcnt     <= '0;
                r_blink_ph <= ~r_blink_ph;
            end else begin
                r_bcnt <= r_bcnt + BW'(1);
            end

            r_an  <= w_an;
            r_seg <= w_seg;
            r_dp  <= w_dp;
        end
    end

    assign an  = r_an;
    assign seg = r_seg;
    assign dp  = r_dp;

endmodule

// File: tb/tb_clock_display_scan.sv
// Purpose : Directed bench for clock_display_scan with REFRESH_DIV=4, BLINK_DIV=16.
// Latency : frame n after reset covers output edges 16n+1..16n+16; it shows the time
//           captured at edge 16n and blink phase n%2.
// Notes   : expected segment patterns per frame are written out by hand below.
module tb_clock_display_scan;

    logic        clk;
    logic        rst;
    logic [15:0] clock_bin;
    logic [1:0]  mode;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S8 = 7'b0000000;
    localparam logic [6:0] S9 = 7'b0010000;
    localparam logic [6:0] SD = 7'b0111111;

    // Digit 3 mask applied when the hour tens digit on screen is zero.
`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [3:0] LZ = 4'b1000;
`else
    localparam logic [3:0] LZ = 4'b0000;
`endif

    clock_display_scan #(
        .REFRESH_DIV (4),
        .BLINK_DIV   (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clock_bin (clock_bin),
        .mode      (mode),
        .an        (an),
        .seg       (seg),
        .dp        (dp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Step through output slots first_i..last_i of one frame and check every edge.
    // s3..s0 are the segment patterns for digits 3..0, blank marks dark digits,
    // dp2 is the expected decimal point while digit 2 is lit.
    task automatic run_frame(input string tag, input int first_i, input int last_i,
                             input logic [6:0] s3, input logic [6:0] s2,
                             input logic [6:0] s1, input logic [6:0] s0,
                             input logic [3:0] blank, input logic dp2);
        logic [6:0] segs [4];
        logic [3:0] one;
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
        int slot;
        segs[0] = s0;
        segs[1] = s1;
        segs[2] = s2;
        segs[3] = s3;
        one     = 4'b0001;
        for (int i = first_i; i <= last_i; i++) begin
            @(posedge clk);
            #1;
            slot = i / 4;
            if (blank[slot]) begin
                exp_an  = 4'b1111;
                exp_seg = 7'b1111111;
            end else begin
                exp_an  = ~(one << slot);
                exp_seg = segs[slot];
            end
            check($sformatf("%s.an[%0d]", tag, i), {28'd0, an}, {28'd0, exp_an});
            check($sformatf("%s.seg[%0d]", tag, i), {25'd0, seg}, {25'd0, exp_seg});
            if (slot != 2) begin
                check($sformatf("%s.dp[%0d]", tag, i), {31'd0, dp}, 32'd1);
            end else if (!blank[slot]) begin
                check($sformatf("%s.dp[%0d]", tag, i), {31'd0, dp}, {31'd0, dp2});
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        clock_bin = 16'h1234;
        mode      = 2'd0;
        #2;
        check("rst.an",  {28'd0, an},  32'hF);
        check("rst.seg", {25'd0, seg}, 32'h7F);
        check("rst.dp",  {31'd0, dp},  32'd1);
        @(negedge clk);
        rst = 1'b0;

        // Frame 0 shows the reset snapshot 0000.
        run_frame("f0", 0, 15, S0, S0, S0, S0, LZ, 1'b0);
        // Frames 1-2: 12:34 with colon following the blink phase.
        run_frame("f1", 0, 15, S1, S2, S3, S4, 4'b0000, 1'b1);
        run_frame("f2", 0, 15, S1, S2, S3, S4, 4'b0000, 1'b0);

        // Anti-tear: time changes while digit 1 is on screen.
        run_frame("f3a", 0, 4, S1, S2, S3, S4, 4'b0000, 1'b1);
        clock_bin = 16'h2359;
        run_frame("f3b", 5, 15, S1, S2, S3, S4, 4'b0000, 1'b1);
        run_frame("f4a", 0, 0, S2, S3, S5, S9, 4'b0000, 1'b0);
        clock_bin = 16'h0845;
        run_frame("f4b", 1, 15, S2, S3, S5, S9, 4'b0000, 1'b0);

        // Hour set: hour digits blink, colon steady.
        mode = 2'd1;
        run_frame("f5", 0, 15, S0, S8, S4, S5, 4'b1100 | LZ, 1'b0);
        run_frame("f6", 0, 15, S0, S8, S4, S5, LZ, 1'b0);

        // Minute set: minute digits blink; queue an invalid-BCD time.
        mode      = 2'd2;
        clock_bin = 16'h2A5F;
        run_frame("f7", 0, 15, S0, S8, S4, S5, 4'b0011 | LZ, 1'b0);

        // Invalid BCD nibbles show a dash.
        mode = 2'd0;
        run_frame("f8a", 0, 0, S2, SD, S5, SD, 4'b0000, 1'b0);
        clock_bin = 16'h0945;
        run_frame("f8b", 1, 15, S2, SD, S5, SD, 4'b0000, 1'b0);

        // Leading zero hour.
        run_frame("f9", 0, 15, S0, S9, S4, S5, LZ, 1'b1);
        run_frame("f10", 0, 5, S0, S9, S4, S5, LZ, 1'b0);

        // Mid-frame asynchronous reset.
        clock_bin = 16'h1234;
        #2;
        rst = 1'b1;
        #1;
        check("mrst.an",  {28'd0, an},  32'hF);
        check("mrst.seg", {25'd0, seg}, 32'h7F);
        check("mrst.dp",  {31'd0, dp},  32'd1);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        run_frame("r0", 0, 15, S0, S0, S0, S0, LZ, 1'b0);
        run_frame("r1", 0, 15, S1, S2, S3, S4, 4'b0000, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Safety net in case the stimulus ever stalls.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/clock_display_scan.md
# clock_display_scan

Consumes the 16-bit BCD time word (HH:MM, four nibbles) produced by the clock tracker and drives a 4-digit, common-anode, time-multiplexed seven-segment display. Snapshots the time word once per full scan to prevent tearing. Blinks the digit group being edited in the set modes and flashes the colon (decimal point on digit 2) in run mode. Sits between the time-keeping core and the board's `an`/`seg`/`dp` pins.

## Interface
- `REFRESH_DIV`, 50000: clock cycles each digit is held; minimum 2.
- `BLINK_DIV`, 25000000: clock cycles per blink half-period; minimum 2.

- `clk`  in  1  system clock
- `rst`  in  1  asynchronous, active-high reset
- `clock_bin`  in  16  BCD time: [15:12] hour tens, [11:8] hour units, [7:4] minute tens, [3:0] minute units
- `mode`  in  2  0/3 = run, 1 = hour set, 2 = minute set
- `an`  out  4  digit enables, active low; `an[0]` = minute units (rightmost)
- `seg`  out  7  {g,f,e,d,c,b,a}, active low
- `dp`  out  1  decimal point, active low; asserted only while digit 2 is selected

## Operation
- **Prescaler `pcnt`**
  - Counts 0..REFRESH_DIV-1 and wraps.
  - Terminal count is the scan tick.
- **Digit index `dig`** (2 bits)
  - Advances 0→1→2→3→0 on each scan tick.
- **Snapshot register `snap`** (16 bits)
  - Loads `clock_bin` on the scan tick when `dig`==3, i.e. as the scan wraps to 0.
  - Changes to `clock_bin` mid-scan are never visible until the next wrap.
- **Blink counter**
  - Counts 0..BLINK_DIV-1.
  - `blink_ph` toggles at terminal count.
- **Digit decode**
  - 0 `1000000`, 1 `1111001`, 2 `0100100`, 3 `0110000`, 4 `0011001`, 5 `0010010`, 6 `0000010`, 7 `1111000`, 8 `0000000`, 9 `0010000`.
  - Nibble >9 shows dash `0111111`.
- **Blinking (set modes)**
  - `mode`==1 and `blink_ph`==1: digits 3 and 2 are blanked.
  - `mode`==2 and `blink_ph`==1: digits 1 and 0 are blanked.
  - A blanked digit drives `an`=`1111` and `seg`=`1111111` for its slot.
- **Colon (`dp` while `dig`==2)**
  - Run mode: `dp` = `blink_ph` (flashing).
  - Set modes: `dp`=0 (solid on).
  - `dp`=1 whenever `dig`≠2.
- **Mode changes**
  - Take effect on the next output register update. No scan restart.
  - `blink_ph` is not reset on a mode change.

## Timing
- **Reset (asynchronous)**
  - `pcnt`=0, `dig`=0, `snap`=0, blink counter=0, `blink_ph`=0.
  - `an`=`1111`, `seg`=`1111111`, `dp`=1.
- **Registered outputs**
  - `an`/`seg`/`dp` are registered from `dig`, `snap`, `mode`, `blink_ph`.
  - Latency: 1 clock after the state change.
- **First clock edge after reset deassertion:** `an`=`1110`, `seg`=`1000000` (snap=0, digit 0).
- **Digit dwell:** exactly REFRESH_DIV cycles per digit; full frame = 4·REFRESH_DIV cycles.
- **Snapshot timing**
  - A new `clock_bin` appears on `seg` at most 4·REFRESH_DIV+1 cycles after it is applied.
  - The new value is first shown on digit 0.
- **Simultaneous events:** a scan tick and a blink toggle on the same edge both apply. Output uses the pre-edge values and reflects both one cycle later.
- **Mid-scan reset:** all state returns to reset values immediately (asynchronous); no partial frame is completed.

## Configuration
- `LEADING_ZERO_BLANK_EN`
  - **Defined:** when `snap[15:12]`==0, digit 3 is blanked (`an[3]` held 1, `seg`=`1111111`) in every mode, so 09:45 displays " 945".
  - **Undefined:** digit 3 displays `0` normally.
  - Blink and dash rules are unchanged.

## Test plan
All scenarios use REFRESH_DIV=4, BLINK_DIV=16.
- **Reset:** assert `rst` mid-frame with `clock_bin`=`0x1234` → `an`=`1111`, `seg`=`1111111`, `dp`=1 immediately. One edge after release: `an`=`1110`, `seg`=`1000000`.
- **Scan and decode:** `clock_bin`=`0x1234`, run 2 frames → second frame `an` sequence `1110`,`1101`,`1011`,`0111`, each 4 cycles long. `seg`=4 `0011001`, 3 `0110000`, 2 `0100100`, 1 `1111001`. `dp`=`blink_ph` only during `1011`.
- **Snapshot anti-tear:** change `clock_bin` from `0x1234` to `0x2359` while `dig`==1 → digits 1–3 of the current frame still show 3, 2, 1. The next frame shows 9, 5, 3, 2.
- **Set-mode blink:** `mode`=1, `clock_bin`=`0x0845` → while `blink_ph`=1, slots 3 and 2 have `an`=`1111`. Slots 1/0 still show 4/5. `dp` stays 0 during slot 2 whenever that slot is not blanked. `mode`=2 → slots 1 and 0 blank instead.
- **Invalid BCD:** `clock_bin`=`0x2A5F` → digits 2 and 0 show `0111111`. Digits 3/1 show 2/5.
- **Leading zero:** `clock_bin`=`0x0945` → with `LEADING_ZERO_BLANK_EN`, slot 3 `an`=`1111`; without it, slot 3 `seg`=`1000000`.
